// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: the byte width and
// the scheduler state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The winner is the first set request
// found when searching upward from ptr+1, wrapping modulo NREQ. Produces a
// one-hot grant, the winner index and a flag that any request won.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_gnt
);

  logic [IDW-1:0] cand;

  // Scan the requests starting just after the pointer; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (!any_gnt && req[cand]) begin
        any_gnt   = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-wide UART transmitter among NREQ
// requesters. Bytes are accepted over per-requester valid/ready handshakes
// and forwarded to the transmitter with a one-cycle tx_start pulse; the
// transmitter busy flag sequences frames back-to-back, and a frame whose
// busy flag never rises is abandoned after BUSY_TIMEOUT cycles.
// Optional build macro UART_TX_SCHED_LOCK_EN adds packet locking: after a
// byte with req_last low the scheduler only serves that requester until a
// byte with req_last high has been accepted.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [DATA_W*NREQ-1:0]   req_data,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [NREQ-1:0]          req_last,
  output logic                     locked,
`endif
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     timeout_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = 8;

  sched_state_t    state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  win_idx;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] win_gnt;
  logic            win_any;
  logic            accept;
  logic            timeout_hit;
  logic [TW-1:0]   timer;

`ifdef UART_TX_SCHED_LOCK_EN
  // While locked only the requester that owns the packet may compete.
  always_comb begin
    arb_req = req_valid;
    if (locked) begin
      arb_req = req_valid & (NREQ'(1) << grant_id);
    end
  end
`else
  // Every byte is arbitrated on its own.
  always_comb begin
    arb_req = req_valid;
  end
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .gnt     (win_gnt),
    .gnt_idx (win_idx),
    .any_gnt (win_any)
  );

  // Next-state and handshake decode; ready is suppressed by a busy
  // transmitter or an asserted reset so nothing is offered during either.
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    tx_start    = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && !tx_busy && win_any) begin
          req_ready = win_gnt;
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: latch the accepted byte and winner, run the busy watchdog
  // and keep the sticky timeout flag. The pointer resets to NREQ-1 so that
  // requester 0 is first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data     <= '0;
      grant_id    <= '0;
      rr_ptr      <= IDW'(NREQ - 1);
      timer       <= '0;
      timeout_err <= 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
      locked      <= 1'b0;
`endif
    end else begin
      if (accept) begin
        tx_data  <= req_data[DATA_W*win_idx +: DATA_W];
        grant_id <= win_idx;
        rr_ptr   <= win_idx;
`ifdef UART_TX_SCHED_LOCK_EN
        locked   <= !req_last[win_idx];
`endif
      end
      if (state == ISSUE) begin
        timer <= '0;
      end else if (state == WAIT_BUSY && !tx_busy) begin
        timer <= timer + 1'b1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
`ifdef UART_TX_SCHED_LOCK_EN
        locked      <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched. Requesters are modelled as byte
// queues, the transmitter as a busy flag that rises two cycles after
// tx_start, and a scoreboard holds the expected grant/byte of every frame.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int BTO  = 5;

  typedef struct packed {
    logic [1:0] gid;
    logic [7:0] data;
    logic       lck;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [1:0]        grant_id;
  logic              timeout_err;
`ifdef UART_TX_SCHED_LOCK_EN
  logic [NREQ-1:0]   req_last;
  logic              locked;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [7:0] srcq [NREQ][$];
  bit   busy_en = 1'b0;
  int   busy_len = 4;
  int   busy_delay = 0;
  int   busy_left = 0;
  bit   model_busy = 1'b0;
  bit   ext_busy = 1'b0;
  bit   pkt_mode = 1'b0;
  bit   tmo_watch = 1'b0;
  int   tmo_mark = -1;

  uart_tx_sched #(
    .NREQ         (NREQ),
    .BUSY_TIMEOUT (BTO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
`ifdef UART_TX_SCHED_LOCK_EN
    .req_last    (req_last),
    .locked      (locked),
`endif
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refreshInputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]      = (srcq[i].size() > 0);
      req_data[8*i +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
`ifdef UART_TX_SCHED_LOCK_EN
      req_last[i]       = pkt_mode ? (srcq[i].size() == 1) : 1'b1;
`endif
    end
    tx_busy = model_busy | ext_busy;
  endtask

  task automatic loadReq(input int i, input logic [7:0] b);
    srcq[i].push_back(b);
  endtask

  task automatic pushExp(input logic [1:0] g, input logic [7:0] d, input logic l);
    exp_t e;
    e.gid  = g;
    e.data = d;
    e.lck  = l;
    sb.push_back(e);
  endtask

  task automatic doReset();
    reset = 1'b1;
    model_busy = 1'b0;
    busy_delay = 0;
    ext_busy = 1'b0;
    pkt_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) srcq[i].delete();
    sb.delete();
    refreshInputs();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs ncyc cycles: outputs sampled on the falling edge, inputs and the
  // transmitter model updated just after the rising edge.
  task automatic applyStimulus(input int ncyc);
    logic [NREQ-1:0] acc;
    exp_t e;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      cyc++;
      acc = req_valid & req_ready;
      checkOutput("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      checkOutput("ready_while_busy", 32'((|req_ready) && tx_busy), 0);
      if (tx_start) begin
        checkOutput("start_while_busy", 32'(tx_busy), 0);
        checkOutput("start_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("tx_data", 32'(tx_data), 32'(e.data));
          checkOutput("grant_id", 32'(grant_id), 32'(e.gid));
`ifdef UART_TX_SCHED_LOCK_EN
          checkOutput("locked", 32'(locked), 32'(e.lck));
`endif
        end
        if (busy_en) busy_delay = 2;
        if (tmo_watch && tmo_mark < 0) tmo_mark = cyc;
      end
      if (tmo_watch && tmo_mark >= 0) begin
        if (cyc == tmo_mark + 5) checkOutput("timeout_early", 32'(timeout_err), 0);
        if (cyc == tmo_mark + 6) begin
          checkOutput("timeout_set", 32'(timeout_err), 1);
          tmo_watch = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) void'(srcq[i].pop_front());
      end
      if (busy_delay > 0) begin
        busy_delay--;
        if (busy_delay == 0) begin
          model_busy = 1'b1;
          busy_left = busy_len;
        end
      end else if (model_busy) begin
        busy_left--;
        if (busy_left == 0) model_busy = 1'b0;
      end
      refreshInputs();
    end
  endtask

  // Directed test sequence.
  initial begin
    refreshInputs();
    #3;
    checkOutput("rst_ready", 32'(req_ready), 0);
    checkOutput("rst_start", 32'(tx_start), 0);
    checkOutput("rst_data", 32'(tx_data), 0);
    checkOutput("rst_grant", 32'(grant_id), 0);
    checkOutput("rst_tmo", 32'(timeout_err), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] busy timeout, dropped byte, next requester served");
    busy_en = 1'b0;
    tmo_watch = 1'b1;
    tmo_mark = -1;
    loadReq(2, 8'h33);
    loadReq(3, 8'h44);
    pushExp(2'd2, 8'h33, 1'b0);
    pushExp(2'd3, 8'h44, 1'b0);
    refreshInputs();
    applyStimulus(40);
    checkOutput("tmo_sticky", 32'(timeout_err), 1);
    checkOutput("tmo_drained", 32'(sb.size()), 0);
    checkOutput("tmo_watch_done", 32'(tmo_watch), 0);

    $display("[TB] single requester, long busy");
    doReset();
    checkOutput("tmo_cleared", 32'(timeout_err), 0);
    busy_en = 1'b1;
    busy_len = 870;
    loadReq(1, 8'hA5);
    loadReq(1, 8'hA6);
    pushExp(2'd1, 8'hA5, 1'b0);
    pushExp(2'd1, 8'hA6, 1'b0);
    refreshInputs();
    applyStimulus(1850);
    checkOutput("single_drained", 32'(sb.size()), 0);
    checkOutput("single_grant", 32'(grant_id), 1);
    checkOutput("single_no_tmo", 32'(timeout_err), 0);

    $display("[TB] external busy blocks, then all four round-robin");
    doReset();
    busy_len = 6;
    ext_busy = 1'b1;
    loadReq(0, 8'h10);
    loadReq(0, 8'h10);
    loadReq(1, 8'h11);
    loadReq(2, 8'h12);
    loadReq(3, 8'h13);
    refreshInputs();
    applyStimulus(20);
    checkOutput("blocked_q0", 32'(srcq[0].size()), 2);
    ext_busy = 1'b0;
    pushExp(2'd0, 8'h10, 1'b0);
    pushExp(2'd1, 8'h11, 1'b0);
    pushExp(2'd2, 8'h12, 1'b0);
    pushExp(2'd3, 8'h13, 1'b0);
    pushExp(2'd0, 8'h10, 1'b0);
    refreshInputs();
    applyStimulus(120);
    checkOutput("rr_drained", 32'(sb.size()), 0);

    $display("[TB] reset during a frame");
    doReset();
    busy_len = 50;
    loadReq(1, 8'h55);
    pushExp(2'd1, 8'h55, 1'b0);
    refreshInputs();
    applyStimulus(12);
    checkOutput("pre_rst_data", 32'(tx_data), 32'h55);
    checkOutput("pre_rst_grant", 32'(grant_id), 1);
    checkOutput("pre_rst_busy", 32'(tx_busy), 1);
    loadReq(0, 8'h77);
    loadReq(1, 8'h66);
    refreshInputs();
    #2 reset = 1'b1;
    model_busy = 1'b0;
    busy_delay = 0;
    refreshInputs();
    #1;
    checkOutput("mid_rst_ready", 32'(req_ready), 0);
    checkOutput("mid_rst_start", 32'(tx_start), 0);
    checkOutput("mid_rst_data", 32'(tx_data), 0);
    checkOutput("mid_rst_grant", 32'(grant_id), 0);
    checkOutput("mid_rst_tmo", 32'(timeout_err), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    busy_len = 4;
    pushExp(2'd0, 8'h77, 1'b0);
    pushExp(2'd1, 8'h66, 1'b0);
    refreshInputs();
    applyStimulus(60);
    checkOutput("post_rst_drained", 32'(sb.size()), 0);

`ifdef UART_TX_SCHED_LOCK_EN
    $display("[TB] packet lock");
    doReset();
    pkt_mode = 1'b1;
    busy_len = 4;
    loadReq(0, 8'hA0);
    loadReq(0, 8'hA1);
    loadReq(0, 8'hA2);
    loadReq(1, 8'hB0);
    pushExp(2'd0, 8'hA0, 1'b1);
    pushExp(2'd0, 8'hA1, 1'b1);
    pushExp(2'd0, 8'hA2, 1'b0);
    pushExp(2'd1, 8'hB0, 1'b0);
    refreshInputs();
    applyStimulus(80);
    checkOutput("lock_drained", 32'(sb.size()), 0);
    checkOutput("lock_released", 32'(locked), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
